// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_pkg
// Brief    : Shared state encoding and default constants for mem_stage_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int C_TIMEOUT_DEFAULT = 64;
    localparam int C_TMR_W           = 16;

endpackage
`default_nettype wire

// File: rtl/mem_stage_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with enable, synchronous clear, async active-low reset;
//            holds at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : Memory-stage sequencer: request issue, pipeline stall/bubble,
//            halt and sticky error/timeout reporting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validM,
    input  logic             readEnM,
    input  logic             memWrtM,
    input  logic             createDumpM,
    input  logic             memDone,
    input  logic             memStall,
    input  logic             memErr,
    output logic             memRd,
    output logic             memWr,
    output logic             stallXM,
    output logic             bubbleW,
    output logic             haltOut,
    output logic             errOut,
    output logic [CNT_W-1:0] stallCnt
);

    localparam logic [C_TMR_W-1:0] c_TIMEOUT = C_TMR_W'(TIMEOUT);

    state_t               r_state;
    state_t               w_next;
    logic                 r_rd_iss;
    logic                 r_wr_iss;
    logic                 r_halt;
    logic                 r_err;
    logic                 w_acc;
    logic                 w_illegal;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_stall;
    logic                 w_bubble;
    logic                 w_in_wait_next;
    logic                 w_cnt_en;
    logic [C_TMR_W-1:0]   w_timer;

    assign w_acc     = validM & (readEnM | memWrtM);
    assign w_illegal = validM & readEnM & memWrtM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_rd_iss <= 1'b0;
            r_wr_iss <= 1'b0;
            r_halt   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && (w_next == ST_WAIT)) begin
                r_rd_iss <= readEnM;
                r_wr_iss <= memWrtM;
            end
            r_halt <= r_halt | (w_next == ST_HALT);
            r_err  <= r_err  | (w_next == ST_ERR);
        end
    end

    always_comb begin
        w_next   = r_state;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_illegal) begin
                    w_next   = ST_ERR;
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (validM && createDumpM) begin
                    w_next  = ST_HALT;
                    w_stall = 1'b1;
                end else if (w_acc && memStall) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_acc) begin
                    w_rd = readEnM;
                    w_wr = memWrtM;
                    if (memErr) begin
                        w_next   = ST_ERR;
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end else if (!memDone) begin
                        w_next   = ST_WAIT;
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_rd = r_rd_iss;
                w_wr = r_wr_iss;
                // Error outranks a coincident done; done releases the pipe on this edge.
                if (memErr) begin
                    w_next   = ST_ERR;
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (memDone) begin
                    w_next = ST_IDLE;
                end else begin
                    if (w_timer == c_TIMEOUT) begin
                        w_next = ST_ERR;
                    end
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            ST_HALT, ST_ERR: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Timer reads 1 in the first WAIT cycle and is held at 0 everywhere else.
    assign w_in_wait_next = (w_next == ST_WAIT);

    sat_counter #(
        .WIDTH (C_TMR_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (!w_in_wait_next),
        .en  (w_in_wait_next),
        .cnt (w_timer)
    );

    assign w_cnt_en = w_stall & ((r_state == ST_IDLE) | (r_state == ST_WAIT));

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (w_cnt_en),
        .cnt (stallCnt)
    );

    assign memRd   = rst & w_rd;
    assign memWr   = rst & w_wr;
    assign stallXM = rst & w_stall;
    assign bubbleW = rst & w_bubble;
    assign haltOut = r_halt;
    assign errOut  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Brief    : Directed self-checking bench for mem_stage_ctrl (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        validM = 1'b0;
    logic        readEnM = 1'b0;
    logic        memWrtM = 1'b0;
    logic        createDumpM = 1'b0;
    logic        memDone = 1'b0;
    logic        memStall = 1'b0;
    logic        memErr = 1'b0;
    logic        memRd;
    logic        memWr;
    logic        stallXM;
    logic        bubbleW;
    logic        haltOut;
    logic        errOut;
    logic [15:0] stallCnt;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .validM      (validM),
        .readEnM     (readEnM),
        .memWrtM     (memWrtM),
        .createDumpM (createDumpM),
        .memDone     (memDone),
        .memStall    (memStall),
        .memErr      (memErr),
        .memRd       (memRd),
        .memWr       (memWr),
        .stallXM     (stallXM),
        .bubbleW     (bubbleW),
        .haltOut     (haltOut),
        .errOut      (errOut),
        .stallCnt    (stallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        validM      = 1'b0;
        readEnM     = 1'b0;
        memWrtM     = 1'b0;
        createDumpM = 1'b0;
        memDone     = 1'b0;
        memStall    = 1'b0;
        memErr      = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // Reset holds outputs low even with a load presented
        validM  = 1'b1;
        readEnM = 1'b1;
        #2;
        chk("rst_memRd",    32'(memRd),    32'd0);
        chk("rst_stallXM",  32'(stallXM),  32'd0);
        chk("rst_bubbleW",  32'(bubbleW),  32'd0);
        chk("rst_haltOut",  32'(haltOut),  32'd0);
        chk("rst_errOut",   32'(errOut),   32'd0);
        chk("rst_stallCnt", 32'(stallCnt), 32'd0);
        cyc();
        cyc();
        idle_in();
        rst = 1'b1;
        #1;
        chk("idle_stallXM", 32'(stallXM), 32'd0);

        // Zero-wait load
        validM  = 1'b1;
        readEnM = 1'b1;
        memDone = 1'b1;
        #1;
        chk("zw_memRd",   32'(memRd),   32'd1);
        chk("zw_stallXM", 32'(stallXM), 32'd0);
        chk("zw_bubbleW", 32'(bubbleW), 32'd0);
        cyc();
        idle_in();
        #1;
        chk("zw_stallCnt", 32'(stallCnt), 32'd0);
        chk("zw_idle_rd",  32'(memRd),    32'd0);
        chk("zw_idle_stl", 32'(stallXM),  32'd0);

        // Three-cycle store
        do_reset();
        validM  = 1'b1;
        memWrtM = 1'b1;
        #1;
        chk("st_c1_memWr",   32'(memWr),   32'd1);
        chk("st_c1_stallXM", 32'(stallXM), 32'd1);
        chk("st_c1_bubbleW", 32'(bubbleW), 32'd1);
        cyc();
        chk("st_c2_memWr",   32'(memWr),   32'd1);
        chk("st_c2_stallXM", 32'(stallXM), 32'd1);
        cyc();
        memDone = 1'b1;
        #1;
        chk("st_c3_memWr",   32'(memWr),   32'd1);
        chk("st_c3_stallXM", 32'(stallXM), 32'd0);
        chk("st_c3_bubbleW", 32'(bubbleW), 32'd0);
        cyc();
        idle_in();
        #1;
        chk("st_stallCnt", 32'(stallCnt), 32'd2);
        chk("st_after_wr", 32'(memWr),    32'd0);
        chk("st_after_sx", 32'(stallXM),  32'd0);

        // memStall for two cycles then zero-wait load
        do_reset();
        validM   = 1'b1;
        readEnM  = 1'b1;
        memStall = 1'b1;
        #1;
        chk("ms_c1_memRd",   32'(memRd),   32'd0);
        chk("ms_c1_stallXM", 32'(stallXM), 32'd1);
        cyc();
        chk("ms_c2_memRd",   32'(memRd),   32'd0);
        chk("ms_c2_bubbleW", 32'(bubbleW), 32'd1);
        cyc();
        memStall = 1'b0;
        memDone  = 1'b1;
        #1;
        chk("ms_c3_memRd",   32'(memRd),   32'd1);
        chk("ms_c3_stallXM", 32'(stallXM), 32'd0);
        cyc();
        idle_in();
        #1;
        chk("ms_stallCnt", 32'(stallCnt), 32'd2);

        // Timeout: issue, then four WAIT cycles, then ERR
        do_reset();
        validM  = 1'b1;
        readEnM = 1'b1;
        #1;
        chk("to_issue_rd", 32'(memRd), 32'd1);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("to_w4_memRd",  32'(memRd),  32'd1);
        chk("to_w4_errOut", 32'(errOut), 32'd0);
        cyc();
        chk("to_err_errOut",  32'(errOut),  32'd1);
        chk("to_err_memRd",   32'(memRd),   32'd0);
        chk("to_err_stallXM", 32'(stallXM), 32'd1);
        chk("to_stallCnt",    32'(stallCnt), 32'd5);
        cyc();
        chk("to_err_hold",   32'(errOut),   32'd1);
        chk("to_cnt_frozen", 32'(stallCnt), 32'd5);

        // Halt, later memErr ignored
        do_reset();
        validM      = 1'b1;
        createDumpM = 1'b1;
        #1;
        chk("hl_stallXM", 32'(stallXM), 32'd1);
        chk("hl_memRd",   32'(memRd),   32'd0);
        chk("hl_haltOut0", 32'(haltOut), 32'd0);
        cyc();
        createDumpM = 1'b0;
        readEnM     = 1'b1;
        memErr      = 1'b1;
        #1;
        chk("hl_haltOut1", 32'(haltOut), 32'd1);
        chk("hl_memRd_h",  32'(memRd),   32'd0);
        cyc();
        chk("hl_err_ign",  32'(errOut),   32'd0);
        chk("hl_haltOut2", 32'(haltOut),  32'd1);
        chk("hl_stallCnt", 32'(stallCnt), 32'd1);

        // Illegal load+store
        do_reset();
        validM  = 1'b1;
        readEnM = 1'b1;
        memWrtM = 1'b1;
        #1;
        chk("il_memRd",   32'(memRd),   32'd0);
        chk("il_memWr",   32'(memWr),   32'd0);
        chk("il_bubbleW", 32'(bubbleW), 32'd1);
        cyc();
        chk("il_errOut",  32'(errOut),  32'd1);
        chk("il_haltOut", 32'(haltOut), 32'd0);

        // memErr beats memDone in WAIT
        do_reset();
        validM  = 1'b1;
        memWrtM = 1'b1;
        cyc();
        memErr  = 1'b1;
        memDone = 1'b1;
        #1;
        chk("ed_stallXM", 32'(stallXM), 32'd1);
        cyc();
        chk("ed_errOut", 32'(errOut), 32'd1);

        // Asynchronous reset in the middle of WAIT
        do_reset();
        validM  = 1'b1;
        readEnM = 1'b1;
        cyc();
        chk("rw_memRd_pre", 32'(memRd),    32'd1);
        chk("rw_cnt_pre",   32'(stallCnt), 32'd1);
        rst = 1'b0;
        #1;
        chk("rw_memRd",    32'(memRd),    32'd0);
        chk("rw_stallXM",  32'(stallXM),  32'd0);
        chk("rw_haltOut",  32'(haltOut),  32'd0);
        chk("rw_errOut",   32'(errOut),   32'd0);
        chk("rw_stallCnt", 32'(stallCnt), 32'd0);
        idle_in();
        #1;
        rst = 1'b1;
        #1;
        cyc();
        chk("rw_post_rd", 32'(memRd),   32'd0);
        chk("rw_post_sx", 32'(stallXM), 32'd0);
        validM  = 1'b1;
        readEnM = 1'b1;
        memDone = 1'b1;
        #1;
        chk("rw_zw_rd", 32'(memRd),   32'd1);
        chk("rw_zw_sx", 32'(stallXM), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the memory stage for multi-cycle data memory (stall-capable, Done/Stall/err handshake).
- Decides per cycle whether the X/M pipeline latch and all upstream latches advance or hold.
- Decides whether the M/W latch receives a bubble.
- Owns halt sequencing for createDump and sticky error/timeout reporting.

Parameters:
- TIMEOUT, 64, max cycles an access may wait for memDone before declaring an error (2..65535).
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets)
- validM  input  1  M stage holds a real (non-bubble) instruction
- readEnM  input  1  M-stage instruction is a load
- memWrtM  input  1  M-stage instruction is a store
- createDumpM  input  1  M-stage instruction is HALT/dump
- memDone  input  1  memory finished the current access; read data valid this cycle
- memStall  input  1  memory busy, cannot accept a new request
- memErr  input  1  memory error/alignment fault
- memRd  output  1  read request to data memory
- memWr  output  1  write request to data memory
- stallXM  output  1  hold X/M latch and all earlier latches and PC
- bubbleW  output  1  force M/W latch to a no-op (no register writeback)
- haltOut  output  1  sticky, processor halted (registered)
- errOut  output  1  sticky, error (registered)
- stallCnt  output  CNT_W  saturating count of cycles with stallXM=1 (registered)

Behaviour:
- States: IDLE, WAIT, HALT, ERR. State, timer, counters and sticky flags are registered; reset state is IDLE.
- Reset (rst=0, asynchronous):
  - State=IDLE, timer=0, haltOut=0, errOut=0, stallCnt=0.
  - While rst=0, memRd, memWr, stallXM and bubbleW are forced to 0 regardless of inputs.
- acc = validM & (readEnM | memWrtM). illegal = validM & readEnM & memWrtM.
- IDLE:
  - validM & createDumpM -> HALT next cycle. stallXM=1 this cycle, no memory request.
  - illegal or memErr during a request -> ERR next cycle. stallXM=1, bubbleW=1.
  - acc & memStall: no request. stallXM=1, bubbleW=1. Stay IDLE.
  - acc & !memStall:
    - Assert memRd=readEnM or memWr=memWrtM combinationally.
    - If memDone in the same cycle (zero-wait hit): stallXM=0, bubbleW=0, stay IDLE.
    - Else go to WAIT with timer=1. stallXM=1, bubbleW=1.
  - !acc: all outputs 0, latches advance.
- WAIT:
  - Hold memRd/memWr at their issued values every cycle until memDone.
  - memErr (wins over memDone in the same cycle) -> ERR.
  - memDone -> IDLE. stallXM=0 and bubbleW=0 in that cycle, so the load data is captured and the pipeline advances on the same edge.
  - Else if timer==TIMEOUT -> ERR. Otherwise timer+1. stallXM=1, bubbleW=1.
- HALT:
  - haltOut=1 from the first cycle in HALT.
  - stallXM=1, bubbleW=1, memRd=memWr=0.
  - Terminal until reset.
- ERR:
  - errOut=1 from the first cycle in ERR.
  - stallXM=1, bubbleW=1, no requests.
  - Terminal until reset. ERR has priority over HALT.
- stallCnt: increments on each clock edge where stallXM=1 and state is IDLE or WAIT. Saturates at all-ones. Frozen in HALT and ERR.
- Requests never issue while memStall=1. Exactly one access is outstanding at a time.
- Reset mid-WAIT: request drops immediately. No retry after reset.
- Latency:
  - Zero-wait access adds 0 stall cycles.
  - An access completing N cycles after issue stalls exactly N cycles.

Decomposition:
- Shared package:
  - State encoding (2-bit IDLE/WAIT/HALT/ERR).
  - Default TIMEOUT constant.
- One sub-module, sat_counter (width-parameterised, enable, async active-low clear, saturating). Used for both the timer and stallCnt.
- FSM and output decode stay in mem_stage_ctrl.

Test Plan:
- Zero-wait load: validM=1, readEnM=1, memDone=1 in the same cycle -> memRd=1, stallXM=0, bubbleW=0, state stays IDLE, stallCnt=0.
- 3-cycle store: memWrtM=1, memDone on the 3rd cycle after issue:
  - memWr held for 3 cycles.
  - stallXM=1, bubbleW=1 for 2 cycles, then 0 on the Done cycle.
  - stallCnt=2.
- memStall=1 for 2 cycles, then a zero-wait load -> no memRd during the memStall cycles, stallXM=1 for 2 cycles, then load completes; stallCnt=2.
- Timeout with TIMEOUT=4 and memDone never asserted -> ERR after 4 wait cycles; errOut=1 and stallXM=1 persist; memRd=0.
- createDumpM=1 with validM=1 -> haltOut=1 next cycle; memErr afterwards is ignored. readEnM=memWrtM=1 -> errOut=1.
- Assert rst=0 mid-WAIT -> memRd, stallXM, haltOut, errOut and stallCnt are 0 immediately (asynchronous); state is IDLE after release.
